jtag_tap_ctrl: RTL and testbench
================================

JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

Interface
REQ-001 Parameter IR_WIDTH, default 4: instruction register width.
REQ-002 Parameter IDCODE_VAL, default 32'h0000_0001: device ID; bit 0 SHALL be 1.
REQ-003 Parameter OP_IDCODE, default 4'b0001: IDCODE opcode.
REQ-004 Parameter OP_TDRR, default 4'b0010: selects the 33-bit test data register.
REQ-005 Parameter OP_BYPASS, default 4'b1111: BYPASS opcode.
REQ-006 TCLK  in  1  test clock, the only clock; all state on posedge unless stated.
REQ-007 TRESET  in  1  asynchronous, active-high reset.
REQ-008 TMS  in  1  mode select, sampled on posedge TCLK.
REQ-009 TDI  in  1  serial data in.
REQ-010 TDRR_SO  in  1  serial output of the test data register.
REQ-011 TDO  out  1  serial data out, registered on negedge TCLK.
REQ-012 TDO_EN  out  1  high while TDO carries valid shift data.
REQ-013 CaptureDR / ShiftDR / UpdateDR  out  1 each  DR strobes to the test data register.
REQ-014 TDRR_Enable  out  1  select of the test data register.
REQ-015 TDRR_SI  out  1  serial input to the test data register (equals TDI).
REQ-016 IR_out  out  IR_WIDTH  current active instruction.

Function
REQ-017 FSM SHALL implement the 16 IEEE 1149.1 TAP states: Test-Logic-Reset, Run-Test/Idle, Select-DR, Capture-DR, Shift-DR, Exit1-DR, Pause-DR, Exit2-DR, Update-DR, and the same six-plus-select IR branch.
REQ-018 Transitions on posedge TCLK per TMS: TLR(0->RTI,1->TLR); RTI(0->RTI,1->SelDR); SelDR(0->CapDR,1->SelIR); SelIR(0->CapIR,1->TLR); Cap(0->Shift,1->Exit1); Shift(0->Shift,1->Exit1); Exit1(0->Pause,1->Update); Pause(0->Pause,1->Exit2); Exit2(0->Shift,1->Update); Update(0->RTI,1->SelDR).
REQ-019 Five consecutive TMS=1 cycles SHALL reach TLR from any state.
REQ-020 CaptureDR, ShiftDR, UpdateDR SHALL be combinational decodes of state Capture-DR, Shift-DR, Update-DR; glitch-free (one-hot or Gray-decoded state).
REQ-021 IR shift register: Capture-IR loads {0..0,2'b01}; Shift-IR shifts right, TDI into MSB.
REQ-022 Active instruction SHALL load from IR shift register on negedge TCLK in Update-IR only.
REQ-023 In TLR, active instruction SHALL be forced to OP_IDCODE.
REQ-024 Unknown opcodes SHALL decode as BYPASS.
REQ-025 TDRR_Enable = (active instruction == OP_TDRR); stable except at Update-IR negedge.
REQ-026 Bypass register (1 bit): cleared at Capture-DR, loads TDI in Shift-DR, when BYPASS selected.
REQ-027 IDCODE register (32 bits): loads IDCODE_VAL at Capture-DR, shifts right with TDI into MSB in Shift-DR, when IDCODE selected.
REQ-028 TDO source: Shift-IR -> IR shift LSB; Shift-DR -> TDRR_SO, IDCODE LSB or bypass bit per decode.
REQ-029 TDO and TDO_EN SHALL update on negedge TCLK; TDO_EN=1 exactly for negedges in Shift-DR or Shift-IR; TDO holds last value otherwise.
REQ-030 Pause states SHALL hold all shift registers unchanged.

Reset
REQ-031 TRESET=1 SHALL asynchronously force: state TLR, active instruction OP_IDCODE, IR shift 0, bypass 0, IDCODE reg 0, TDO 0, TDO_EN 0.
REQ-032 Strobe outputs SHALL be 0 and TDRR_Enable 0 during and after reset until a state/instruction change.
REQ-033 Reset asserted mid-shift SHALL abort the scan; no Update strobe issued.

Verification
REQ-034 From each of 16 states, TMS=1 x5 -> state TLR, IR_out=OP_IDCODE.
REQ-035 Reset, TMS 0,1,0,0 then 32 Shift-DR cycles -> TDO stream LSB-first = 32'h0000_0001, TDO_EN high 32 negedges.
REQ-036 Shift IR 4'b0010 via Shift-IR, Update-IR -> TDRR_Enable=1; DR scan with 33 cycles -> CaptureDR 1 cycle, ShiftDR 33, UpdateDR 1, TDRR_SI mirrors TDI.
REQ-037 Load 4'b1111 then DR shift TDI pattern 1,0,1,1 -> TDO 0,1,0,1 (one-cycle delay through bypass).
REQ-038 Load 4'b0111 -> behaves as BYPASS; IR capture scan out returns 4'b0001 LSB-first (1,0,0,0).
REQ-039 TRESET pulse in Shift-DR at cycle 10 -> state TLR, UpdateDR never asserts, TDO_EN=0.

Source files
------------

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller. It holds the 16-state TAP FSM, the instruction
// register, and the BYPASS and IDCODE data registers. It also drives the strobes
// that control an external 33-bit test data register (TDRR).
module jtag_tap_ctrl #(
    parameter int unsigned          IR_WIDTH   = 4,
    parameter logic [31:0]          IDCODE_VAL = 32'h0000_0001,
    parameter logic [IR_WIDTH-1:0]  OP_IDCODE  = 4'b0001,
    parameter logic [IR_WIDTH-1:0]  OP_TDRR    = 4'b0010,
    parameter logic [IR_WIDTH-1:0]  OP_BYPASS  = 4'b1111
) (
    input  logic                TCLK,
    input  logic                TRESET,
    input  logic                TMS,
    input  logic                TDI,
    input  logic                TDRR_SO,
    output logic                TDO,
    output logic                TDO_EN,
    output logic                CaptureDR,
    output logic                ShiftDR,
    output logic                UpdateDR,
    output logic                TDRR_Enable,
    output logic                TDRR_SI,
    output logic [IR_WIDTH-1:0] IR_out
);

    // One-hot state encoding: each DR strobe is a single flop output, so it cannot glitch
    localparam logic [15:0] ST_TLR    = 16'h0001;
    localparam logic [15:0] ST_RTI    = 16'h0002;
    localparam logic [15:0] ST_SEL_DR = 16'h0004;
    localparam logic [15:0] ST_CAP_DR = 16'h0008;
    localparam logic [15:0] ST_SH_DR  = 16'h0010;
    localparam logic [15:0] ST_EX1_DR = 16'h0020;
    localparam logic [15:0] ST_PAU_DR = 16'h0040;
    localparam logic [15:0] ST_EX2_DR = 16'h0080;
    localparam logic [15:0] ST_UPD_DR = 16'h0100;
    localparam logic [15:0] ST_SEL_IR = 16'h0200;
    localparam logic [15:0] ST_CAP_IR = 16'h0400;
    localparam logic [15:0] ST_SH_IR  = 16'h0800;
    localparam logic [15:0] ST_EX1_IR = 16'h1000;
    localparam logic [15:0] ST_PAU_IR = 16'h2000;
    localparam logic [15:0] ST_EX2_IR = 16'h4000;
    localparam logic [15:0] ST_UPD_IR = 16'h8000;

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

    logic [15:0]         state_q, state_d;
    logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic                byp_q, byp_d;
    logic [31:0]         idc_q, idc_d;
    logic                tdo_q, tdo_d;
    logic                tdo_en_q, tdo_en_d;

    logic in_tlr, in_cap_dr, in_sh_dr, in_upd_dr, in_cap_ir, in_sh_ir, in_upd_ir;
    logic sel_idcode, sel_tdrr, sel_bypass;

    assign in_tlr    = |(state_q & ST_TLR);
    assign in_cap_dr = |(state_q & ST_CAP_DR);
    assign in_sh_dr  = |(state_q & ST_SH_DR);
    assign in_upd_dr = |(state_q & ST_UPD_DR);
    assign in_cap_ir = |(state_q & ST_CAP_IR);
    assign in_sh_ir  = |(state_q & ST_SH_IR);
    assign in_upd_ir = |(state_q & ST_UPD_IR);

    // Any opcode other than IDCODE or TDRR selects the bypass register
    assign sel_idcode = (ir_q == OP_IDCODE);
    assign sel_tdrr   = (ir_q == OP_TDRR);
    assign sel_bypass = (ir_q == OP_BYPASS) || !(sel_idcode || sel_tdrr);

    assign CaptureDR   = in_cap_dr;
    assign ShiftDR     = in_sh_dr;
    assign UpdateDR    = in_upd_dr;
    assign TDRR_Enable = sel_tdrr;
    assign TDRR_SI     = TDI;
    assign IR_out      = ir_q;
    assign TDO         = tdo_q;
    assign TDO_EN      = tdo_en_q;

    // TAP next-state decode, steered by TMS
    always_comb begin
        state_d = ST_TLR;
        case (state_q)
            ST_TLR:    state_d = TMS ? ST_TLR    : ST_RTI;
            ST_RTI:    state_d = TMS ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR: state_d = TMS ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR: state_d = TMS ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:  state_d = TMS ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR: state_d = TMS ? ST_UPD_DR : ST_PAU_DR;
            ST_PAU_DR: state_d = TMS ? ST_EX2_DR : ST_PAU_DR;
            ST_EX2_DR: state_d = TMS ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR: state_d = TMS ? ST_SEL_DR : ST_RTI;
            ST_SEL_IR: state_d = TMS ? ST_TLR    : ST_CAP_IR;
            ST_CAP_IR: state_d = TMS ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:  state_d = TMS ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR: state_d = TMS ? ST_UPD_IR : ST_PAU_IR;
            ST_PAU_IR: state_d = TMS ? ST_EX2_IR : ST_PAU_IR;
            ST_EX2_IR: state_d = TMS ? ST_UPD_IR : ST_SH_IR;
            ST_UPD_IR: state_d = TMS ? ST_SEL_DR : ST_RTI;
            default:   state_d = ST_TLR;
        endcase
    end

    // Next values of the IR shift register and the two internal data registers
    always_comb begin
        ir_sr_d = ir_sr_q;
        byp_d   = byp_q;
        idc_d   = idc_q;
        if (in_cap_ir) begin
            ir_sr_d = IR_CAPTURE;
        end else if (in_sh_ir) begin
            ir_sr_d = {TDI, ir_sr_q[IR_WIDTH-1:1]};
        end
        if (sel_bypass) begin
            if (in_cap_dr) begin
                byp_d = 1'b0;
            end else if (in_sh_dr) begin
                byp_d = TDI;
            end
        end
        if (sel_idcode) begin
            if (in_cap_dr) begin
                idc_d = IDCODE_VAL;
            end else if (in_sh_dr) begin
                idc_d = {TDI, idc_q[31:1]};
            end
        end
    end

    // Next values of the active instruction and the TDO source mux
    always_comb begin
        ir_d     = ir_q;
        tdo_d    = tdo_q;
        tdo_en_d = 1'b0;
        if (in_tlr) begin
            ir_d = OP_IDCODE;
        end else if (in_upd_ir) begin
            ir_d = ir_sr_q;
        end
        if (in_sh_ir) begin
            tdo_d    = ir_sr_q[0];
            tdo_en_d = 1'b1;
        end else if (in_sh_dr) begin
            tdo_en_d = 1'b1;
            if (sel_tdrr) begin
                tdo_d = TDRR_SO;
            end else if (sel_idcode) begin
                tdo_d = idc_q[0];
            end else begin
                tdo_d = byp_q;
            end
        end
    end

    // Registers on the rising edge: FSM state and all shift registers
    always_ff @(posedge TCLK or posedge TRESET) begin
        if (TRESET) begin
            state_q <= ST_TLR;
            ir_sr_q <= '0;
            byp_q   <= 1'b0;
            idc_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_sr_q <= ir_sr_d;
            byp_q   <= byp_d;
            idc_q   <= idc_d;
        end
    end

    // Registers on the falling edge: active instruction, TDO and TDO_EN
    always_ff @(negedge TCLK or posedge TRESET) begin
        if (TRESET) begin
            ir_q     <= OP_IDCODE;
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            ir_q     <= ir_d;
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl. It uses a table of TMS paths that visits every
// TAP state, and hand-written scans for IDCODE, TDRR, BYPASS, pause and reset.
module tb_jtag_tap_ctrl;

    logic       TCLK = 1'b0;
    logic       TRESET, TMS, TDI, TDRR_SO;
    logic       TDO, TDO_EN, CaptureDR, ShiftDR, UpdateDR, TDRR_Enable, TDRR_SI;
    logic [3:0] IR_out;

    jtag_tap_ctrl #(
        .IR_WIDTH   (4),
        .IDCODE_VAL (32'h0000_0001),
        .OP_IDCODE  (4'b0001),
        .OP_TDRR    (4'b0010),
        .OP_BYPASS  (4'b1111)
    ) dut (
        .TCLK        (TCLK),
        .TRESET      (TRESET),
        .TMS         (TMS),
        .TDI         (TDI),
        .TDRR_SO     (TDRR_SO),
        .TDO         (TDO),
        .TDO_EN      (TDO_EN),
        .CaptureDR   (CaptureDR),
        .ShiftDR     (ShiftDR),
        .UpdateDR    (UpdateDR),
        .TDRR_Enable (TDRR_Enable),
        .TDRR_SI     (TDRR_SI),
        .IR_out      (IR_out)
    );

    always #5 TCLK = ~TCLK;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // Samples taken by tick(): strobes just after posedge, TDO side just after negedge
    logic       s_cap, s_sh, s_upd, s_si, s_tdo, s_en, s_te;
    logic [3:0] s_ir;
    logic       so_v = 1'b0;
    int unsigned cap_cnt, sh_cnt, upd_cnt;

    typedef struct {
        string       name;
        int unsigned len;
        logic [7:0]  tms;
        logic        cap;
        logic        sh;
        logic        upd;
        logic        en;
        logic [3:0]  ir;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mkv(input string n, input int unsigned l, input logic [7:0] t,
                                 input logic c, input logic s, input logic u,
                                 input logic e, input logic [3:0] i);
        vec_t v;
        v.name = n; v.len = l; v.tms = t; v.cap = c; v.sh = s; v.upd = u; v.en = e; v.ir = i;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        TDRR_SO = so_v;
        @(posedge TCLK);
        #1;
        s_cap = CaptureDR;
        s_sh  = ShiftDR;
        s_upd = UpdateDR;
        s_si  = TDRR_SI;
        cap_cnt += 32'(s_cap);
        sh_cnt  += 32'(s_sh);
        upd_cnt += 32'(s_upd);
        @(negedge TCLK);
        #1;
        s_tdo = TDO;
        s_en  = TDO_EN;
        s_ir  = IR_out;
        s_te  = TDRR_Enable;
    endtask

    // From RTI: load val through Shift-IR and return the captured bits (LSB first). Ends in RTI.
    task automatic ir_scan(input logic [3:0] val, output logic [3:0] cap_out);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        cap_out[0] = s_tdo;
        for (int i = 0; i < 4; i++) begin
            tick(i == 3, val[i]);
            if (i < 3) cap_out[i+1] = s_tdo;
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    // From RTI: four-bit DR scan. out holds the TDO seen on each Shift-DR negedge. Ends in RTI.
    task automatic dr_scan4(input logic [3:0] pat, output logic [3:0] out);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        out[0] = s_tdo;
        for (int i = 0; i < 4; i++) begin
            tick(i == 3, pat[i]);
            if (i < 3) out[i+1] = s_tdo;
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] stream;
        logic [3:0]  co, dout;
        int unsigned en_cnt, si_bad, so_bad;
        logic        d;

        // TMS paths, applied LSB first, that lead from RTI to each TAP state
        vecs[0]  = mkv("TLR",     3, 8'h07, 0, 0, 0, 0, 4'h1);
        vecs[1]  = mkv("RTI",     0, 8'h00, 0, 0, 0, 0, 4'hF);
        vecs[2]  = mkv("SelDR",   1, 8'h01, 0, 0, 0, 0, 4'hF);
        vecs[3]  = mkv("CapDR",   2, 8'h01, 1, 0, 0, 0, 4'hF);
        vecs[4]  = mkv("ShDR",    3, 8'h01, 0, 1, 0, 1, 4'hF);
        vecs[5]  = mkv("Ex1DR",   3, 8'h05, 0, 0, 0, 0, 4'hF);
        vecs[6]  = mkv("PauDR",   4, 8'h05, 0, 0, 0, 0, 4'hF);
        vecs[7]  = mkv("Ex2DR",   5, 8'h15, 0, 0, 0, 0, 4'hF);
        vecs[8]  = mkv("UpdDR",   4, 8'h0D, 0, 0, 1, 0, 4'hF);
        vecs[9]  = mkv("SelIR",   2, 8'h03, 0, 0, 0, 0, 4'hF);
        vecs[10] = mkv("CapIR",   3, 8'h03, 0, 0, 0, 0, 4'hF);
        vecs[11] = mkv("ShIR",    4, 8'h03, 0, 0, 0, 1, 4'hF);
        vecs[12] = mkv("Ex1IR",   4, 8'h0B, 0, 0, 0, 0, 4'hF);
        vecs[13] = mkv("PauIR",   5, 8'h0B, 0, 0, 0, 0, 4'hF);
        vecs[14] = mkv("Ex2IR",   6, 8'h2B, 0, 0, 0, 0, 4'hF);
        vecs[15] = mkv("UpdIR",   5, 8'h1B, 0, 0, 0, 0, 4'h1);

        cap_cnt = 0; sh_cnt = 0; upd_cnt = 0;
        TRESET = 1'b1; TMS = 1'b1; TDI = 1'b0; TDRR_SO = 1'b0;
        @(negedge TCLK);
        #1;
        chk("rst_tdo", TDO, 1'b0);
        chk("rst_tdo_en", TDO_EN, 1'b0);
        chk("rst_strobes", {CaptureDR, ShiftDR, UpdateDR, TDRR_Enable}, 4'b0000);
        chk("rst_ir", IR_out, 4'b0001);
        TRESET = 1'b0;

        // IDCODE scan straight after reset
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        chk("idc_capture", s_cap, 1'b1);
        tick(1'b0, 1'b0);
        stream[0] = s_tdo;
        en_cnt = 32'(s_en);
        for (int i = 1; i < 32; i++) begin
            tick(1'b0, i[0]);
            stream[i] = s_tdo;
            en_cnt += 32'(s_en);
        end
        tick(1'b1, 1'b0);
        chk("idc_en_exit", s_en, 1'b0);
        chk("idc_stream", stream, 32'h0000_0001);
        chk("idc_en_cnt", en_cnt, 32);
        tick(1'b1, 1'b0);
        chk("idc_update", s_upd, 1'b1);
        tick(1'b0, 1'b0);

        // TDRR instruction and a 33-bit DR scan
        ir_scan(4'b0010, co);
        chk("tdrr_ir_capture", co, 4'b0001);
        chk("tdrr_ir", s_ir, 4'b0010);
        chk("tdrr_enable", s_te, 1'b1);
        cap_cnt = 0; sh_cnt = 0; upd_cnt = 0; si_bad = 0; so_bad = 0;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 33; i++) begin
            so_v = 1'($urandom);
            d    = 1'($urandom);
            tick(1'b0, d);
            if (s_si !== d) si_bad++;
            if (s_tdo !== so_v || s_en !== 1'b1) so_bad++;
        end
        so_v = 1'b0;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        chk("tdrr_cap_cnt", cap_cnt, 1);
        chk("tdrr_sh_cnt", sh_cnt, 33);
        chk("tdrr_upd_cnt", upd_cnt, 1);
        chk("tdrr_si_bad", si_bad, 0);
        chk("tdrr_so_bad", so_bad, 0);
        chk("tdrr_enable_hold", s_te, 1'b1);

        // BYPASS: one-cycle delay through the bypass bit
        ir_scan(4'b1111, co);
        chk("byp_ir", s_ir, 4'b1111);
        chk("byp_tdrr_enable", s_te, 1'b0);
        dr_scan4(4'b1101, dout);
        chk("byp_stream", dout, 4'b1010);
        chk("byp_tdo_hold", s_tdo, 1'b1);
        chk("byp_en_idle", s_en, 1'b0);

        // Pause-DR must not disturb the bypass bit
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("pause_en", s_en, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        chk("pause_resume_tdo", s_tdo, 1'b1);
        chk("pause_resume_en", s_en, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);

        // An unknown opcode behaves as BYPASS
        ir_scan(4'b0111, co);
        chk("unk_ir_capture", co, 4'b0001);
        chk("unk_ir", s_ir, 4'b0111);
        chk("unk_tdrr_enable", s_te, 1'b0);
        dr_scan4(4'b1011, dout);
        chk("unk_stream", dout, 4'b0110);

        // From every state, five TMS=1 cycles return to Test-Logic-Reset
        foreach (vecs[k]) begin
            ir_scan(4'hF, co);
            for (int j = 0; j < int'(vecs[k].len); j++) tick(vecs[k].tms[j], 1'b0);
            chk({"path_strobes_", vecs[k].name}, {s_cap, s_sh, s_upd}, {vecs[k].cap, vecs[k].sh, vecs[k].upd});
            chk({"path_en_", vecs[k].name}, s_en, vecs[k].en);
            chk({"path_ir_", vecs[k].name}, s_ir, vecs[k].ir);
            for (int j = 0; j < 5; j++) tick(1'b1, 1'b0);
            chk({"tlr_ir_", vecs[k].name}, s_ir, 4'b0001);
            chk({"tlr_strobes_", vecs[k].name}, {s_cap, s_sh, s_upd, s_te}, 4'b0000);
            tick(1'b0, 1'b0);
            tick(1'b1, 1'b0);
            tick(1'b0, 1'b0);
            chk({"tlr_path_capdr_", vecs[k].name}, s_cap, 1'b1);
            tick(1'b1, 1'b0);
            tick(1'b1, 1'b0);
            tick(1'b0, 1'b0);
        end

        // Reset pulse in the middle of a DR scan
        ir_scan(4'hF, co);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        for (int i = 0; i < 9; i++) tick(1'b0, 1'b1);
        chk("abort_pre_tdo", s_tdo, 1'b1);
        upd_cnt = 0;
        TRESET = 1'b1;
        #2;
        chk("abort_tdo_en", TDO_EN, 1'b0);
        chk("abort_tdo", TDO, 1'b0);
        chk("abort_shiftdr", ShiftDR, 1'b0);
        chk("abort_ir", IR_out, 4'b0001);
        TRESET = 1'b0;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        chk("abort_en_after", s_en, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        chk("abort_tlr_capdr", s_cap, 1'b1);
        chk("abort_no_update", upd_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
